cdc_word_sender: RTL

Source-side (clockIn domain) end of the toggle request/acknowledge word crossing. It accepts one WIDTH-bit word per transaction on a valid/ready port and holds that word stable on `dataHold`. It flips `reqToggle` to signal the clockOut-domain receiver, then waits until the receiver's acknowledge toggle, synchronised back into clockIn, matches. A timeout watchdog flags a receiver that never answers.

---
 rtl/cdc_pkg.sv | 18 +
 rtl/sync_chain.sv | 27 ++
 rtl/cdc_word_sender.sv | 96 +++++++++
 3 files changed

// File: rtl/cdc_pkg.sv
// Definitions shared by both ends of the toggle request/acknowledge word crossing.
package cdc_pkg;

    typedef enum logic [1:0] {ALIGN, IDLE, WAIT} cdc_state_t;

    localparam int DEFAULT_SYNC_STAGES = 2;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single toggle level crossing into clk.
module sync_chain
    import cdc_pkg::*;
#(
    parameter int STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // The chain keeps sampling while rst is high, so q already reflects the far
    // side at reset release; the sender's ALIGN state depends on that.
    (* async_reg = "true", shreg_extract = "no", dont_touch = "true" *)
    logic [STAGES-1:0] sync_q;

    logic unused_rst;
    assign unused_rst = rst;

    always_ff @(posedge clk) begin
        sync_q <= {sync_q[STAGES-2:0], d};
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_word_sender.sv
// Source-side end of the toggle req/ack word crossing: holds one word stable,
// flips reqToggle and waits for the synchronised acknowledge to match.
module cdc_word_sender
    import cdc_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int TIMEOUT     = 1023
) (
    input  logic             clockIn,
    input  logic             s_reset0,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             validIn,
    output logic             readyOut,
    output logic [WIDTH-1:0] dataHold,
    output logic             reqToggle,
    input  logic             ackToggleAsync,
    output logic             busy,
    output logic             timeoutError,
    input  logic             clearError
);

    localparam int               CNT_W   = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic             WDOG_ON = (TIMEOUT > 0);

    cdc_state_t       state;
    logic             ackSync;
    logic [CNT_W-1:0] wait_cnt;
    logic             acked;
    logic             accept;
    logic             timeout_hit;

    sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk(clockIn),
        .rst(s_reset0),
        .d  (ackToggleAsync),
        .q  (ackSync)
    );

    assign acked       = (ackSync == reqToggle);
    assign accept      = validIn && readyOut;
    // Fires on the edge that moves the counter onto TIMEOUT.
    assign timeout_hit = WDOG_ON && (state == WAIT) && (wait_cnt == CNT_MAX - 1'b1);

    always_ff @(posedge clockIn or posedge s_reset0) begin
        if (s_reset0) begin
            state        <= ALIGN;
            readyOut     <= 1'b0;
            busy         <= 1'b0;
            reqToggle    <= 1'b0;
            dataHold     <= '0;
            wait_cnt     <= '0;
            timeoutError <= 1'b0;
        end else begin
            case (state)
                ALIGN: begin
                    if (acked) begin
                        state    <= IDLE;
                        readyOut <= 1'b1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        state     <= WAIT;
                        readyOut  <= 1'b0;
                        busy      <= 1'b1;
                        dataHold  <= dataIn;
                        reqToggle <= ~reqToggle;
                        wait_cnt  <= '0;
                    end
                end
                WAIT: begin
                    if (WDOG_ON && (wait_cnt != CNT_MAX)) wait_cnt <= wait_cnt + 1'b1;
                    // A late acknowledge still completes normally after a timeout.
                    if (acked) begin
                        state    <= IDLE;
                        readyOut <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state    <= ALIGN;
                    readyOut <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase

            if (timeout_hit) timeoutError <= 1'b1;
            else if (clearError) timeoutError <= 1'b0;
        end
    end

endmodule
